// File: rtl/sf_tester_pattern_engine.sv
// Pattern byte generator (TX side) and read-back checker (RX side) for the serial-flash tester.
// Gen data follows state with no added latency; mismatch/error updates land 1 cycle after the accepted byte; checker never stalls.
module sf_tester_pattern_engine #(
    parameter int PARM_CNT_WIDTH = 9,
    parameter int PARM_ERR_WIDTH = 32
) (
    input  logic                      i_clk_40mhz,
    input  logic                      i_rst_40mhz,
    input  logic                      i_load_pattern,
    input  logic [7:0]                i_start_val,
    input  logic [7:0]                i_incr_val,
    input  logic                      i_clr_errors,
    input  logic                      i_gen_start,
    input  logic                      i_chk_start,
    input  logic [PARM_CNT_WIDTH-1:0] i_byte_count,
    output logic                      o_gen_valid,
    output logic [7:0]                o_gen_data,
    input  logic                      i_gen_ready,
    input  logic                      i_chk_valid,
    input  logic [7:0]                i_chk_data,
    output logic                      o_chk_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_mismatch,
    output logic [PARM_ERR_WIDTH-1:0] o_err_count,
    output logic                      o_err_sticky
);

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_CHK, ST_DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [7:0]                gen_seed;
    logic [7:0]                chk_seed;
    logic [7:0]                incr;
    logic [PARM_CNT_WIDTH-1:0] remaining;
    logic                      gen_xfer;
    logic                      chk_xfer;
    logic                      last_byte;
    logic                      idle;

    assign idle        = (state == ST_IDLE);
    assign o_gen_valid = (state == ST_GEN);
    assign o_gen_data  = gen_seed;
    assign o_chk_ready = (state == ST_CHK);
    assign o_busy      = !idle;
    assign o_done      = (state == ST_DONE);
    assign gen_xfer    = o_gen_valid && i_gen_ready;
    assign chk_xfer    = o_chk_ready && i_chk_valid;
    assign last_byte   = (remaining == PARM_CNT_WIDTH'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // Gen has priority when both start pulses coincide.
                if (i_gen_start) begin
                    state_nxt = (i_byte_count == '0) ? ST_DONE : ST_GEN;
                end else if (i_chk_start) begin
                    state_nxt = (i_byte_count == '0) ? ST_DONE : ST_CHK;
                end
            end
            ST_GEN: begin
                if (gen_xfer && last_byte) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_CHK: begin
                if (chk_xfer && last_byte) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_40mhz) begin
        if (i_rst_40mhz) begin
            state        <= ST_IDLE;
            gen_seed     <= 8'h00;
            chk_seed     <= 8'h00;
            incr         <= 8'h01;
            remaining    <= '0;
            o_mismatch   <= 1'b0;
            o_err_count  <= '0;
            o_err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_mismatch <= 1'b0;
            if (idle) begin
                if (i_load_pattern) begin
                    gen_seed <= i_start_val;
                    chk_seed <= i_start_val;
                    incr     <= i_incr_val;
                end
                if (i_clr_errors) begin
                    o_err_count  <= '0;
                    o_err_sticky <= 1'b0;
                end
                if (i_gen_start || i_chk_start) begin
                    remaining <= i_byte_count;
                end
            end
            if (gen_xfer) begin
                gen_seed  <= gen_seed + incr;
                remaining <= remaining - PARM_CNT_WIDTH'(1);
            end
            if (chk_xfer) begin
                chk_seed  <= chk_seed + incr;
                remaining <= remaining - PARM_CNT_WIDTH'(1);
                if (i_chk_data != chk_seed) begin
                    o_mismatch   <= 1'b1;
                    o_err_sticky <= 1'b1;
                    if (o_err_count != '1) begin
                        o_err_count <= o_err_count + PARM_ERR_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sf_tester_pattern_engine.sv
// Self-checking bench for sf_tester_pattern_engine: directed table, hand sequences, randomized runs.
`timescale 1ns/1ps
module tb_sf_tester_pattern_engine;

    localparam int CW     = 9;
    localparam int EW     = 4;
    localparam int ERRMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_pattern = 1'b0;
    logic [7:0]    start_val = 8'h00;
    logic [7:0]    incr_val = 8'h00;
    logic          clr_errors = 1'b0;
    logic          gen_start = 1'b0;
    logic          chk_start = 1'b0;
    logic [CW-1:0] byte_count = '0;
    logic          gen_valid;
    logic [7:0]    gen_data;
    logic          gen_ready = 1'b0;
    logic          chk_valid = 1'b0;
    logic [7:0]    chk_data = 8'h00;
    logic          chk_ready;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [EW-1:0] err_count;
    logic          err_sticky;

    sf_tester_pattern_engine #(.PARM_CNT_WIDTH(CW), .PARM_ERR_WIDTH(EW)) dut (
        .i_clk_40mhz   (clk),
        .i_rst_40mhz   (rst),
        .i_load_pattern(load_pattern),
        .i_start_val   (start_val),
        .i_incr_val    (incr_val),
        .i_clr_errors  (clr_errors),
        .i_gen_start   (gen_start),
        .i_chk_start   (chk_start),
        .i_byte_count  (byte_count),
        .o_gen_valid   (gen_valid),
        .o_gen_data    (gen_data),
        .i_gen_ready   (gen_ready),
        .i_chk_valid   (chk_valid),
        .i_chk_data    (chk_data),
        .o_chk_ready   (chk_ready),
        .o_busy        (busy),
        .o_done        (done),
        .o_mismatch    (mismatch),
        .o_err_count   (err_count),
        .o_err_sticky  (err_sticky)
    );

    always #12.5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pattern value of the next byte on each side, shared increment, error tally.
    logic [7:0] m_gen, m_chk, m_incr;
    int         m_err;
    bit         m_sticky;
    bit         noise;
    logic [7:0] chk_q[$];

    typedef struct {
        bit         load;
        logic [7:0] sv;
        logic [7:0] iv;
        int         count;
        int         mode;
        int         exp_valid;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } gvec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_gen = 8'h00; m_chk = 8'h00; m_incr = 8'h01; m_err = 0; m_sticky = 0;
    endtask

    task automatic do_load(input logic [7:0] sv, input logic [7:0] iv);
        start_val = sv; incr_val = iv; load_pattern = 1'b1;
        tick();
        load_pattern = 1'b0;
        m_gen = sv; m_chk = sv; m_incr = iv;
    endtask

    task automatic do_clear();
        clr_errors = 1'b1;
        tick();
        clr_errors = 1'b0;
        m_err = 0; m_sticky = 0;
    endtask

    // Commands that arrive while a run is active must have no effect.
    task automatic drive_noise();
        if (noise) begin
            load_pattern = ($urandom_range(5) == 0);
            clr_errors   = ($urandom_range(5) == 0);
            gen_start    = ($urandom_range(5) == 0);
            chk_start    = ($urandom_range(5) == 0);
            start_val    = 8'($urandom);
            incr_val     = 8'($urandom);
            byte_count   = CW'($urandom_range(0, 20));
        end
    endtask

    task automatic clear_noise();
        load_pattern = 0; clr_errors = 0; gen_start = 0; chk_start = 0;
    endtask

    // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready.
    task automatic run_gen(input int count, input int mode, input bit both,
                           output int nbytes, output int ndone, output int nvalid,
                           output logic [7:0] first, output logic [7:0] last);
        logic [7:0] held;
        bit stalled;
        bit fin;
        nbytes = 0; ndone = 0; nvalid = 0; first = 8'h00; last = 8'h00;
        held = 8'h00; stalled = 0; fin = 0;
        byte_count = CW'(count); gen_start = 1'b1; chk_start = both;
        tick();
        gen_start = 1'b0; chk_start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            check("gen_chk_ready_low", chk_ready, 0);
            if (done) ndone++;
            if (gen_valid) begin
                nvalid++;
                if (stalled) check("gen_hold", gen_data, held);
                check("gen_data", gen_data, m_gen);
                case (mode)
                    0:       gen_ready = 1'b1;
                    1:       gen_ready = ((nvalid % 2) == 1);
                    default: gen_ready = 1'($urandom_range(1));
                endcase
                if (gen_ready) begin
                    if (nbytes == 0) first = gen_data;
                    last = gen_data;
                    nbytes++;
                    m_gen = m_gen + m_incr;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = gen_data;
                end
            end else begin
                gen_ready = 1'($urandom_range(1));
            end
            if (ndone > 0 && !done) fin = 1;
            else begin
                drive_noise();
                tick();
            end
        end
        clear_noise();
        gen_ready = 1'b0;
    endtask

    // Bytes come from chk_q when it is non-empty, else random with err_pct% wrong.
    task automatic run_chk(input int count, input int err_pct, output int nmis, output int ndone);
        bit pend;
        bit fin;
        nmis = 0; ndone = 0; pend = 0; fin = 0;
        byte_count = CW'(count); chk_start = 1'b1;
        tick();
        chk_start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            check("chk_gen_valid_low", gen_valid, 0);
            check("mismatch_pulse", mismatch, pend);
            if (mismatch) nmis++;
            pend = 0;
            if (done) ndone++;
            if (chk_ready) begin
                chk_valid = (chk_q.size() > 0) ? 1'b1 : ($urandom_range(3) != 0);
                if (chk_valid) begin
                    if (chk_q.size() > 0) chk_data = chk_q.pop_front();
                    else if ($urandom_range(99) < err_pct) chk_data = m_chk ^ 8'($urandom_range(1, 255));
                    else chk_data = m_chk;
                    if (chk_data != m_chk) begin
                        pend = 1;
                        if (m_err < ERRMAX) m_err++;
                        m_sticky = 1;
                    end
                    m_chk = m_chk + m_incr;
                end
            end else begin
                chk_valid = 1'($urandom_range(1));
                chk_data  = 8'($urandom);
            end
            if (ndone > 0 && !done) fin = 1;
            else begin
                drive_noise();
                tick();
            end
        end
        clear_noise();
        chk_valid = 1'b0;
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_err_count"}, err_count, m_err);
        check({tag, "_err_sticky"}, err_sticky, m_sticky);
    endtask

    initial begin
        gvec_t      tbl[5];
        int         nb, nd, nv, nm;
        logic [7:0] f, l, s;

        tbl[0] = '{1'b1, 8'h00, 8'h01, 256, 0, 256, 8'h00, 8'hFF};
        tbl[1] = '{1'b0, 8'h00, 8'h00,   4, 0,   4, 8'h00, 8'h03};
        tbl[2] = '{1'b1, 8'h08, 8'h07,   4, 1,   7, 8'h08, 8'h1D};
        tbl[3] = '{1'b1, 8'hFF, 8'h02,   3, 2,  -1, 8'hFF, 8'h03};
        tbl[4] = '{1'b1, 8'h10, 8'h0F,   0, 0,   0, 8'h00, 8'h00};

        noise = 0;
        model_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_gen_valid", gen_valid, 0);
        check("rst_gen_data", gen_data, 8'h00);
        check("rst_chk_ready", chk_ready, 0);
        check("rst_done", done, 0);
        check("rst_mismatch", mismatch, 0);
        check_errs("rst");

        // Directed generator runs.
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].load) do_load(tbl[i].sv, tbl[i].iv);
            run_gen(tbl[i].count, tbl[i].mode, 1'b0, nb, nd, nv, f, l);
            check("tbl_nbytes", nb, tbl[i].count);
            check("tbl_ndone", nd, 1);
            check("tbl_idle_after", busy, 0);
            if (tbl[i].exp_valid >= 0) check("tbl_valid_cycles", nv, tbl[i].exp_valid);
            if (tbl[i].count > 0) begin
                check("tbl_first", f, tbl[i].exp_first);
                check("tbl_last", l, tbl[i].exp_last);
            end
        end

        // Checker: clean pass, then one bad byte among the continued sequence.
        do_load(8'h10, 8'h0F);
        chk_q = '{8'h10, 8'h1F, 8'h2E, 8'h3D};
        run_chk(4, 0, nm, nd);
        check("chk_clean_mis", nm, 0);
        check("chk_clean_done", nd, 1);
        check("chk_clean_err", err_count, 0);
        chk_q = '{8'h4C, 8'h5B, 8'h00, 8'h79};
        run_chk(4, 0, nm, nd);
        check("chk_one_mis", nm, 1);
        check("chk_one_err", err_count, 1);
        check("chk_one_sticky", err_sticky, 1);

        // Valid data while idle is not checked.
        chk_valid = 1'b1; chk_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_valid_mis", mismatch, 0);
        end
        chk_valid = 1'b0;
        check("idle_valid_err", err_count, 1);

        // Saturation and clear.
        s = m_chk;
        for (int i = 0; i < 20; i++) begin
            chk_q.push_back(s ^ 8'hFF);
            s = s + m_incr;
        end
        run_chk(20, 0, nm, nd);
        check("sat_nmis", nm, 20);
        check("sat_err", err_count, 4'hF);
        check("sat_sticky", err_sticky, 1);
        do_clear();
        check("clr_err", err_count, 0);
        check("clr_sticky", err_sticky, 0);

        // Simultaneous starts: generator only; checker seed untouched.
        run_gen(3, 0, 1'b1, nb, nd, nv, f, l);
        check("both_nbytes", nb, 3);
        check("both_ndone", nd, 1);
        chk_q = '{m_chk};
        run_chk(1, 0, nm, nd);
        check("both_chk_seed_intact", nm, 0);

        // Reset in the middle of a gen run.
        byte_count = CW'(8); gen_start = 1'b1;
        tick();
        gen_start = 1'b0; gen_ready = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        model_reset();
        check("midrst_gen_valid", gen_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        rst = 1'b0; gen_ready = 1'b0;
        tick();
        check("midrst_no_done", done, 0);
        run_gen(2, 0, 1'b0, nb, nd, nv, f, l);
        check("midrst_first", f, 8'h00);
        check("midrst_last", l, 8'h01);
        check("midrst_ndone", nd, 1);

        // Randomized operations with ignored-command noise during runs.
        noise = 1;
        for (int it = 0; it < 60; it++) begin
            int cnt;
            cnt = ($urandom_range(15) == 0) ? 256 : int'($urandom_range(0, 30));
            case ($urandom_range(3))
                0: do_load(8'($urandom), 8'($urandom));
                1: do_clear();
                2: begin
                    run_gen(cnt, 2, 1'b0, nb, nd, nv, f, l);
                    check("rnd_gen_nbytes", nb, cnt);
                    check("rnd_gen_ndone", nd, 1);
                end
                default: begin
                    run_chk(cnt, 25, nm, nd);
                    check("rnd_chk_ndone", nd, 1);
                end
            endcase
            check("rnd_idle", busy, 0);
            check_errs("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
